// File: rtl/bcd_disp_pkg.sv
// Shared types, segment patterns and helpers for the BCD result display stage.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        BLANK,
        SHOW,
        ERROR
    } disp_state_t;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_E    = 7'h79;
    localparam logic [6:0] SEG_DARK = 7'h00;

    // A result is displayable only with no overflow and a units digit of 0..9.
    function automatic logic is_valid_bcd(input logic [5:0] res);
        return !res[5] && (res[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_result_display_seg7_decode.sv
// Combinational digit decoder: 0..9 and 0xE map to glyphs, everything else is dark.
// Output is active-high; polarity is applied by the instantiating block.
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DARK;
        if (!blank) begin
            case (digit)
                4'd0:    pattern = SEG_0;
                4'd1:    pattern = SEG_1;
                4'd2:    pattern = SEG_2;
                4'd3:    pattern = SEG_3;
                4'd4:    pattern = SEG_4;
                4'd5:    pattern = SEG_5;
                4'd6:    pattern = SEG_6;
                4'd7:    pattern = SEG_7;
                4'd8:    pattern = SEG_8;
                4'd9:    pattern = SEG_9;
                4'hE:    pattern = SEG_E;
                default: pattern = SEG_DARK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_result_display.sv
// Two-digit multiplexed seven-segment driver for the BCD adder result, with a
// one-deep pending buffer that is committed only at scan-frame boundaries.
module bcd_result_display
    import bcd_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV    = 4096,
    parameter int unsigned BLINK_DIV      = 32,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] res_in,
    input  logic       res_valid,
    output logic       res_ready,
    input  logic       clear,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err
);

    localparam int unsigned RW = $clog2(REFRESH_DIV);
    localparam int unsigned BW = $clog2(2 * BLINK_DIV);
    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_DIV - 1);
    localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_DIV);
    localparam logic [6:0]    SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    disp_state_t   state, state_next;
    logic [RW-1:0] ref_cnt;
    logic          dig;
    logic [BW-1:0] blink_cnt;
    logic          pend_full;
    logic [5:0]    pend;
    logic [5:0]    disp;
    logic          ref_tc, frame_end, accept, commit;
    logic          digit_lit;
    logic [3:0]    digit_val;
    logic [6:0]    pattern;

    assign ref_tc    = (ref_cnt == REF_LAST);
    assign frame_end = ref_tc && dig;
    assign res_ready = !pend_full;
    // clear wins over both the handshake and the commit in the same cycle.
    assign accept    = res_valid && !pend_full && !clear;
    assign commit    = frame_end && pend_full && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BLANK;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clear)       state_next = BLANK;
        else if (commit) state_next = is_valid_bcd(pend) ? SHOW : ERROR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt   <= '0;
            dig       <= 1'b0;
            blink_cnt <= '0;
            pend_full <= 1'b0;
            pend      <= '0;
            disp      <= '0;
        end else begin
            ref_cnt <= ref_tc ? '0 : ref_cnt + 1'b1;
            if (ref_tc) dig <= ~dig;

            if (clear) begin
                pend_full <= 1'b0;
            end else if (commit) begin
                disp      <= pend;
                pend_full <= 1'b0;
            end else if (accept) begin
                pend      <= res_in;
                pend_full <= 1'b1;
            end

            if (commit)
                blink_cnt <= '0;
            else if (frame_end && state == ERROR)
                blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
        end
    end

    // Tens digit only ever shows "1"; leading zero stays dark.
    always_comb begin
        digit_lit = 1'b0;
        digit_val = 4'd0;
        case (state)
            SHOW: begin
                if (!dig) begin
                    digit_lit = 1'b1;
                    digit_val = disp[3:0];
                end else begin
                    digit_lit = disp[4];
                    digit_val = 4'd1;
                end
            end
            ERROR: begin
                if (!dig) begin
                    digit_lit = (blink_cnt < BLINK_HALF);
                    digit_val = 4'hE;
                end
            end
            default: ;
        endcase
    end

    seg7_decode u_decode (
        .digit   (digit_val),
        .blank   (!digit_lit),
        .pattern (pattern)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_OFF;
            an  <= 2'b11;
            err <= 1'b0;
        end else begin
            seg <= SEG_ACTIVE_LOW ? ~pattern : pattern;
            an  <= digit_lit ? (dig ? 2'b01 : 2'b10) : 2'b11;
            err <= (state == ERROR);
        end
    end

endmodule

// File: tb/tb_bcd_result_display.sv
// Self-checking bench for bcd_result_display: cycle-level reference model,
// a table of display vectors, directed corner sequences and random traffic.
module tb_bcd_result_display;

    localparam int unsigned RD = 4;
    localparam int unsigned BD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] res_in = '0;
    logic       res_valid = 1'b0;
    logic       clear = 1'b0;
    logic       res_ready;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;

    always #5 clk = ~clk;

    bcd_result_display #(
        .REFRESH_DIV    (RD),
        .BLINK_DIV      (BD),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .res_in    (res_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .clear     (clear),
        .seg       (seg),
        .an        (an),
        .err       (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Reference model: time is a plain cycle count; the frame is 2*RD cycles,
    // the first RD with the units digit selected, boundary on the last cycle.
    int         m_t = 0;
    bit         m_pf = 0;
    logic [5:0] m_pend = '0;
    logic [5:0] m_val = '0;
    int         m_st = 0;     // 0 dark, 1 showing a number, 2 showing error
    int         m_frames = 0;
    logic [6:0] m_seg = 7'h7F;
    logic [1:0] m_an = 2'b11;
    bit         m_err = 0;
    int         pos, d;
    bit         bnd, lit;
    logic [6:0] on;

    always @(posedge clk) begin
        if (rst) begin
            m_t = 0; m_pf = 0; m_pend = '0; m_val = '0; m_st = 0; m_frames = 0;
            m_seg = 7'h7F; m_an = 2'b11; m_err = 0;
        end else begin
            pos = m_t % (2 * RD);
            d   = pos / RD;
            bnd = (pos == 2 * RD - 1);
            on  = 7'h00;
            lit = 0;
            if (m_st == 1) begin
                if (d == 0) begin lit = 1; on = glyph(m_val[3:0]); end
                else if (m_val[4]) begin lit = 1; on = 7'h06; end
            end else if (m_st == 2 && d == 0 && ((m_frames / BD) % 2 == 0)) begin
                lit = 1; on = 7'h79;
            end
            m_seg = ~on;
            m_an  = lit ? (d == 0 ? 2'b10 : 2'b01) : 2'b11;
            m_err = (m_st == 2);
            if (clear) begin
                m_st = 0; m_pf = 0;
            end else if (bnd && m_pf) begin
                m_val = m_pend; m_pf = 0; m_frames = 0;
                m_st = (!m_pend[5] && m_pend[3:0] < 10) ? 1 : 2;
            end else begin
                if (bnd && m_st == 2) m_frames++;
                if (res_valid && !m_pf) begin m_pend = res_in; m_pf = 1; end
            end
            m_t++;
        end
        #1;
        check("seg", seg, m_seg);
        check("an", an, m_an);
        check("err", err, m_err);
        check("res_ready", res_ready, !m_pf);
    end

    task automatic send(input logic [5:0] v);
        int k = 0;
        @(negedge clk);
        while (!res_ready && k < 40) begin @(negedge clk); k++; end
        check("send_ready", res_ready, 1'b1);
        res_in = v; res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
    endtask

    task automatic expect_dark(input string name, input int cycles);
        bit seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (an != 2'b11) seen = 1;
        end
        check(name, seen, 1'b0);
    endtask

    typedef struct {
        logic [5:0] res;
        logic [6:0] units;
        logic [1:0] tens_an;
        logic [6:0] tens_seg;
        bit         err;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int lat, k, stall;
        logic [6:0] u_seen, t_seg;
        logic [1:0] t_an;

        tbl[0] = '{6'b000111, 7'h78, 2'b11, 7'h7F, 1'b0};
        tbl[1] = '{6'b010010, 7'h24, 2'b01, 7'h79, 1'b0};
        tbl[2] = '{6'b000000, 7'h40, 2'b11, 7'h7F, 1'b0};
        tbl[3] = '{6'b011001, 7'h10, 2'b01, 7'h79, 1'b0};
        tbl[4] = '{6'b001100, 7'h06, 2'b11, 7'h7F, 1'b1};
        tbl[5] = '{6'b100001, 7'h06, 2'b11, 7'h7F, 1'b1};
        tbl[6] = '{6'b010000, 7'h40, 2'b01, 7'h79, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        expect_dark("idle_dark", 12);

        // accept-to-visible latency from a blank display
        send(6'b000111);
        lat = 1;
        while (!(an == 2'b10 && seg == 7'h78) && lat < 20) begin @(negedge clk); lat++; end
        check("latency_le_9", (lat <= 2 * RD + 1), 1'b1);

        foreach (tbl[i]) begin
            send(tbl[i].res);
            repeat (10) @(negedge clk);
            u_seen = 7'h7F; t_an = 2'b11; t_seg = 7'h7F;
            for (int c = 0; c < 2 * RD; c++) begin
                @(negedge clk);
                if (an == 2'b10) u_seen = seg;
                if (an == 2'b01) begin t_an = an; t_seg = seg; end
            end
            check("tbl_units", u_seen, tbl[i].units);
            check("tbl_tens_an", t_an, tbl[i].tens_an);
            check("tbl_tens_seg", t_seg, tbl[i].tens_seg);
            check("tbl_err", err, tbl[i].err);
        end

        // blinking error: let several blink periods run under the model
        send(6'b001100);
        repeat (40) @(negedge clk);
        send(6'b100001);
        repeat (40) @(negedge clk);

        // back-to-back beats: the second must stall until after the commit
        @(negedge clk);
        res_in = 6'b000101; res_valid = 1'b1;
        @(negedge clk);
        res_in = 6'b010011;
        check("bp_stall", res_ready, 1'b0);
        stall = 0;
        while (!res_ready && stall < 30) begin @(negedge clk); stall++; end
        check("bp_released", res_ready, 1'b1);
        @(negedge clk);
        res_valid = 1'b0;
        repeat (24) @(negedge clk);

        // clear together with a valid beat drops the beat
        @(negedge clk);
        res_in = 6'b000011; res_valid = 1'b1; clear = 1'b1;
        @(negedge clk);
        res_valid = 1'b0; clear = 1'b0;
        check("clr_beat_ready", res_ready, 1'b1);
        expect_dark("clr_beat_dark", 20);

        // clear while a result is pending
        k = 0;
        while ((m_t % (2 * RD)) != 1 && k < 20) begin @(negedge clk); k++; end
        res_in = 6'b010101; res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        check("clr_pend_held", res_ready, 1'b0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_pend_ready", res_ready, 1'b1);
        expect_dark("clr_pend_dark", 20);

        // asynchronous reset with a result showing and another pending
        send(6'b011000);
        repeat (12) @(negedge clk);
        send(6'b000100);
        #2 rst = 1'b1;
        #1;
        check("rst_seg", seg, 7'h7F);
        check("rst_an", an, 2'b11);
        check("rst_err", err, 1'b0);
        check("rst_ready", res_ready, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        expect_dark("rst_pend_lost", 20);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            res_valid = ($urandom_range(0, 2) == 0);
            res_in    = 6'($urandom);
            clear     = ($urandom_range(0, 39) == 0);
        end
        @(negedge clk);
        res_valid = 1'b0; clear = 1'b0;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_result_display.md
# bcd_result_display

Registered, time-multiplexed two-digit seven-segment driver that consumes the 6-bit result of the BCD adder stage: tens flag in bit 4, units digit in bits 3:0, overflow in bit 5. It buffers one pending result behind a valid/ready handshake and commits it only at a scan-frame boundary, so a digit never changes mid-frame. It blanks the leading zero and shows a blinking "E" for results that are not legal BCD. It is the output stage of the adder/subtractor datapath.

## Interface
- REFRESH_DIV, 4096: clock cycles each digit is lit (≥2).
- BLINK_DIV, 32: scan frames per half-period of the error blink (≥1).
- SEG_ACTIVE_LOW, 1: 1 = segment lines active-low, 0 = active-high.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- res_in  in  6  adder result; [3:0] units, [4] tens, [5] overflow.
- res_valid  in  1  res_in is valid this cycle.
- res_ready  out  1  block can accept res_in this cycle.
- clear  in  1  synchronous; blank the display and drop any pending result.
- seg  out  7  {g,f,e,d,c,b,a} segment lines, polarity set by SEG_ACTIVE_LOW.
- an  out  2  digit enables, always active-low; an[0] = units, an[1] = tens.
- err  out  1  the displayed result is invalid.

## Operation
- Transfer: a result is accepted when res_valid && res_ready. It is latched into the pending register and pend_full is set. res_ready = !pend_full.
- Scan timing:
  - A refresh counter runs 0..REFRESH_DIV-1 continuously.
  - At terminal count, digit index dig toggles between 0 (units) and 1 (tens).
  - Frame boundary = terminal count while dig = 1.
- Commit: at a frame boundary, if pend_full, pending is copied to the display register and pend_full clears. State is then set from the committed value:
  - invalid (units > 9, or bit 5 = 1) → ERROR;
  - otherwise → SHOW.
- States:
  - BLANK: both digits dark. Entered on reset and on clear.
  - SHOW: units digit is always lit. The tens digit shows "1" when bit 4 = 1 and is dark otherwise (leading-zero blanking).
  - ERROR: units shows "E" (0x79 active-high), tens is dark. The units digit is lit for BLINK_DIV frames, then dark for BLINK_DIV frames, repeating. The blink counter resets on entry to ERROR. err = 1 only in ERROR.
- Enables: an = ~(1 << dig) when the selected digit is lit, 2'b11 otherwise.
- Digit patterns (active-high): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. A dark digit is all segments off. seg is inverted when SEG_ACTIVE_LOW = 1.
- clear:
  - → BLANK, pend_full = 0.
  - Has priority over a simultaneous handshake; that beat is dropped, although res_ready may have been high.
  - Has priority over a commit in the same cycle.
  - The scan counters keep running.
- Simultaneous accept and commit in the same cycle cannot occur, because res_ready is low whenever pend_full = 1.

## Timing
- Reset values: seg all off (7'h7F when SEG_ACTIVE_LOW = 1), an = 2'b11, err = 0, res_ready = 1, state BLANK, all counters 0, dig = 0.
- Registered outputs: seg, an and err all come from flops. seg/an reflect dig one cycle after it changes.
- Accept to pending: 1 cycle.
- Pending to visible: at the next frame boundary.
  - Worst-case latency from accept to outputs: 2·REFRESH_DIV + 1 cycles.
  - Best case: 2 cycles.
- res_ready drops in the cycle after an accept. It rises in the cycle after the commit.
- Reset asserted mid-frame or with a result pending: all state returns to reset values immediately; the pending result is lost.

## Structure
- Package bcd_disp_pkg holds:
  - the state enum {BLANK, SHOW, ERROR};
  - the segment-pattern constants (digits 0–9, E, dark);
  - the function is_valid_bcd(res).
- Sub-module seg7_decode: combinational, 4-bit digit plus blank flag → 7-bit active-high pattern. The top level applies polarity.
- Top level holds the handshake, pending register, refresh and blink counters, state machine, and output flops.

## Test plan
Benches use REFRESH_DIV = 4, BLINK_DIV = 2, SEG_ACTIVE_LOW = 1.
- Reset and idle:
  - Stimulus: assert rst mid-run.
  - Required: outputs are seg = 7F, an = 11, err = 0, res_ready = 1 at once; they stay so with no input.
- Single-digit result:
  - Stimulus: res_in = 6'b000111.
  - Required: after the next frame boundary, the units slot shows an = 10 with seg = ~07 = 78; the tens slot shows an = 11; worst-case latency ≤ 9 cycles.
- Two-digit result:
  - Stimulus: res_in = 6'b010010 (12).
  - Required: units shows seg = ~5B = 24; tens shows an = 01 with seg = ~06 = 79.
- Invalid result:
  - Stimulus: res_in = 6'b001100 (units = 12), then 6'b100001 (overflow).
  - Required: err = 1; units shows seg = ~79 = 06 for 2 frames, then dark for 2 frames, repeating.
- Backpressure:
  - Stimulus: two back-to-back valid beats.
  - Required: the second beat stalls with res_ready = 0 until the cycle after the commit. Both results are displayed in order; none is lost.
- Clear:
  - Stimulus: clear asserted together with res_valid, and again while pend_full = 1.
  - Required: result is BLANK, no capture, pend_full = 0; res_ready = 1 in the following cycle.
